pipe_ctrl: RTL

- Pipeline sequencer and hazard unit for the 4-stage ALU datapath: ID (operand capture into A/B/S), EX (ALU, out1, status1), MEM (out2, status2, memory access), WB (load-data writeback).
- Tracks per-stage instruction state, generates register-capture enables, forwarding mux selects, regfile write controls and status/output register enables.
- Stalls the ID stage on load-use and write-port hazards; squashes EX on flush.

---
 rtl/pipe_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer and hazard unit for the ID/EX/MEM/WB ALU datapath.
// Tracks per-stage instruction state and drives capture, forwarding and writeback controls.
module pipe_ctrl #(
    parameter int PC_REG = 15,
    parameter int FWD_EN = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    output logic       id_ready,
    input  logic [3:0] id_rn,
    input  logic       id_use_rn,
    input  logic [3:0] id_rm,
    input  logic       id_use_rm,
    input  logic [3:0] id_rs,
    input  logic       id_use_rs,
    input  logic [3:0] id_rd,
    input  logic       id_wr_rd,
    input  logic       id_is_load,
    input  logic       id_set_flags,
    input  logic [2:0] id_alu_op,
    input  logic       flush,
    output logic [1:0] sel_A_in,
    output logic [1:0] sel_B_in,
    output logic [1:0] sel_shift_in,
    output logic       en_A,
    output logic       en_B,
    output logic       en_S,
    output logic [2:0] ALU_op,
    output logic       w_en1,
    output logic [3:0] w_addr1,
    output logic       sel_w_data,
    output logic       en_out1,
    output logic       en_out2,
    output logic       en_status1,
    output logic       en_status2
);
    localparam logic [3:0] PC_IDX = PC_REG[3:0];
    localparam logic       FWD_ON = (FWD_EN != 0);

    typedef struct packed {
        logic       valid;
        logic [3:0] rd;
        logic       wr_rd;
        logic       is_load;
        logic       set_flags;
    } stage_t;

    stage_t     ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    logic [2:0] ex_op_q, ex_op_d;

    logic [2:0] src_use, src_fwd, src_stall;
    logic [3:0] src_reg [3];
    logic       port_conflict, stall, capture;
    logic       ex_live, ex_wr_alu, wb_wr_load;

    // Index 0 = A (rn), 1 = B (rm), 2 = shift amount (rs).
    always_comb begin
        src_use   = {id_use_rs, id_use_rm, id_use_rn};
        src_reg[0] = id_rn;
        src_reg[1] = id_rm;
        src_reg[2] = id_rs;
        src_fwd   = '0;
        src_stall = '0;
        for (int i = 0; i < 3; i++) begin
            if (src_use[i] && (src_reg[i] != PC_IDX)) begin
                if (ex_q.valid && ex_q.wr_rd && (ex_q.rd == src_reg[i])) begin
                    if (!ex_q.is_load && FWD_ON) src_fwd[i] = 1'b1;
                    else                         src_stall[i] = 1'b1;
                end
                if (mem_q.valid && mem_q.wr_rd && mem_q.is_load && (mem_q.rd == src_reg[i]))
                    src_stall[i] = 1'b1;
                if (wb_q.valid && wb_q.wr_rd && wb_q.is_load && (wb_q.rd == src_reg[i]))
                    src_stall[i] = 1'b1;
            end
        end
        // An ALU writer entering EX next cycle would meet the MEM load in WB on port 1.
        port_conflict = id_wr_rd & ~id_is_load & mem_q.valid & mem_q.is_load;
        stall         = id_valid & ((|src_stall) | port_conflict);
        capture       = id_valid & ~stall & ~flush;
    end

    always_comb begin
        id_ready     = ~stall;
        en_A         = capture;
        en_B         = capture;
        en_S         = capture;
        sel_A_in     = (id_use_rn && (id_rn == PC_IDX)) ? 2'b11 : (src_fwd[0] ? 2'b01 : 2'b00);
        sel_B_in     = src_fwd[1] ? 2'b01 : 2'b00;
        sel_shift_in = !id_use_rs ? 2'b11 : (src_fwd[2] ? 2'b01 : 2'b00);

        ex_live      = ex_q.valid & ~flush;
        ex_wr_alu    = ex_live & ex_q.wr_rd & ~ex_q.is_load;
        wb_wr_load   = wb_q.valid & wb_q.wr_rd & wb_q.is_load;

        en_out1      = ex_live;
        en_status1   = ex_live & ex_q.set_flags;
        en_out2      = mem_q.valid;
        en_status2   = mem_q.valid & mem_q.set_flags;
        ALU_op       = ex_op_q;
        w_en1        = ex_wr_alu | wb_wr_load;
        w_addr1      = wb_wr_load ? wb_q.rd : ex_q.rd;
        sel_w_data   = wb_wr_load;
    end

    always_comb begin
        ex_d    = ex_q;
        ex_op_d = ex_op_q;
        ex_d.valid = capture;
        if (capture) begin
            ex_d.rd        = id_rd;
            ex_d.wr_rd     = id_wr_rd;
            ex_d.is_load   = id_is_load;
            ex_d.set_flags = id_set_flags;
            ex_op_d        = id_alu_op;
        end
        mem_d = ex_q;
        if (flush) mem_d.valid = 1'b0;
        wb_d = mem_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            ex_op_q <= '0;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
            ex_op_q <= ex_op_d;
        end
    end
endmodule
